banked_mem_ctrl: RTL and testbench

//  Parametrised successor to the single-bank IM/DM SRAM pair: one shared, word-interleaved,

---
 rtl/mem_ctrl_pkg.sv | 29 ++
 rtl/sram_bank.sv | 42 ++++
 rtl/banked_mem_ctrl.sv | 130 +++++++++++++
 tb/tb_banked_mem_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the banked instruction/data memory controller.
package mem_ctrl_pkg;

  // Default configuration: 32-bit words, 14-bit word addresses, 4 banks
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_ADDR_W    = 14;
  localparam int DEF_NUM_BANKS = 4;
  localparam int BANK_BITS     = $clog2(DEF_NUM_BANKS);

  // Requester identity; also used as the round-robin priority pointer
  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_id_e;

  // One memory request as seen by a bank in the default configuration
  typedef struct packed {
    logic                      we;
    logic [DEF_ADDR_W-1:0]     addr;
    logic [DEF_DATA_W/8-1:0]   be;
    logic [DEF_DATA_W-1:0]     wdata;
  } mem_req_t;

  // The port that wins the next conflict after this one has been served
  function automatic port_id_e other_port(input port_id_e p);
    return (p == PORT_I) ? PORT_D : PORT_I;
  endfunction

endpackage

// File: rtl/sram_bank.sv
// Behavioural single-port SRAM bank: active-low chip/write enables,
// per-byte write mask, registered read port. Contents are never reset.
module sram_bank #(
  parameter int DATA_W = 32,
  parameter int ROW_W  = 12
) (
  input  logic                  clk,
  input  logic                  ceb,
  input  logic                  web,
  input  logic [ROW_W-1:0]      addr,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int DEPTH = 2 ** ROW_W;
  localparam int BE_W  = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Byte-masked write; a zero mask leaves the word untouched
  always_ff @(posedge clk) begin
    if (!ceb && !web) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be[b]) begin
          mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  // Registered read; output holds between reads
  always_ff @(posedge clk) begin
    if (!ceb && web) begin
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/banked_mem_ctrl.sv
// Word-interleaved multi-bank memory shared by an instruction read port and
// a data read/write port. Same-bank collisions are resolved round-robin via
// the ready signals; read data returns one cycle after the request fires.
module banked_mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  parameter int INIT_PRIO = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_valid,
  output logic                  i_req_ready,
  input  logic [ADDR_W-1:0]     i_req_addr,
  output logic                  i_rsp_valid,
  output logic [DATA_W-1:0]     i_rsp_data,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic                  d_req_we,
  input  logic [ADDR_W-1:0]     d_req_addr,
  input  logic [DATA_W/8-1:0]   d_req_be,
  input  logic [DATA_W-1:0]     d_req_wdata,
  output logic                  d_rsp_valid,
  output logic [DATA_W-1:0]     d_rsp_data
);

  localparam int       BNK_W     = $clog2(NUM_BANKS);
  localparam int       ROW_W     = ADDR_W - BNK_W;
  localparam port_id_e INIT_PORT = (INIT_PRIO != 0) ? PORT_D : PORT_I;

  // Low address bits pick the bank, the rest pick the row inside it
  logic [BNK_W-1:0] i_bank, d_bank;
  logic [ROW_W-1:0] i_row, d_row;

  assign i_bank = i_req_addr[BNK_W-1:0];
  assign d_bank = d_req_addr[BNK_W-1:0];
  assign i_row  = i_req_addr[ADDR_W-1:BNK_W];
  assign d_row  = d_req_addr[ADDR_W-1:BNK_W];

  logic     conflict;
  logic     i_fire, d_fire;
  port_id_e prio_q, prio_d;

  // Conflict detection and grant; the pointer only moves on a conflict
  always_comb begin
    conflict    = i_req_valid && d_req_valid && (i_bank == d_bank);
    i_req_ready = !conflict || (prio_q == PORT_I);
    d_req_ready = !conflict || (prio_q == PORT_D);
    i_fire      = i_req_valid && i_req_ready;
    d_fire      = d_req_valid && d_req_ready;
    prio_d      = conflict ? other_port(prio_q) : prio_q;
  end

  logic [DATA_W-1:0] bank_rdata [NUM_BANKS];

  // One bank per index; at most one port can fire into a given bank
  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    localparam logic [BNK_W-1:0] BANK_ID = BNK_W'(gi);

    logic             sel_i, sel_d;
    logic             ceb, web;
    logic [ROW_W-1:0] row;

    // Route whichever port fired into this bank
    always_comb begin
      sel_i = i_fire && (i_bank == BANK_ID);
      sel_d = d_fire && (d_bank == BANK_ID);
      ceb   = !(sel_i || sel_d);
      web   = !(sel_d && d_req_we);
      row   = sel_d ? d_row : i_row;
    end

    sram_bank #(
      .DATA_W (DATA_W),
      .ROW_W  (ROW_W)
    ) u_bank (
      .clk   (clk),
      .ceb   (ceb),
      .web   (web),
      .addr  (row),
      .be    (d_req_be),
      .wdata (d_req_wdata),
      .rdata (bank_rdata[gi])
    );
  end

  logic              i_vld_q, i_vld_d, d_vld_q, d_vld_d;
  logic [BNK_W-1:0]  i_sel_q, i_sel_d, d_sel_q, d_sel_d;
  logic [DATA_W-1:0] i_hold_q, i_hold_d, d_hold_q, d_hold_d;

  // Response demux: remember which bank each port read, then select its
  // output for one cycle; otherwise present the last delivered word
  always_comb begin
    i_rsp_data = i_vld_q ? bank_rdata[i_sel_q] : i_hold_q;
    d_rsp_data = d_vld_q ? bank_rdata[d_sel_q] : d_hold_q;
    i_hold_d   = i_rsp_data;
    d_hold_d   = d_rsp_data;
    i_vld_d    = i_fire;
    d_vld_d    = d_fire && !d_req_we;
    i_sel_d    = i_fire ? i_bank : i_sel_q;
    d_sel_d    = d_fire ? d_bank : d_sel_q;
  end

  assign i_rsp_valid = i_vld_q;
  assign d_rsp_valid = d_vld_q;

  // Controller state; reset drops any in-flight response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q   <= INIT_PORT;
      i_vld_q  <= 1'b0;
      d_vld_q  <= 1'b0;
      i_sel_q  <= '0;
      d_sel_q  <= '0;
      i_hold_q <= '0;
      d_hold_q <= '0;
    end else begin
      prio_q   <= prio_d;
      i_vld_q  <= i_vld_d;
      d_vld_q  <= d_vld_d;
      i_sel_q  <= i_sel_d;
      d_sel_q  <= d_sel_d;
      i_hold_q <= i_hold_d;
      d_hold_q <= d_hold_d;
    end
  end

endmodule

// File: tb/tb_banked_mem_ctrl.sv
// Scoreboard bench for banked_mem_ctrl: the driver queues expected read
// data when a request fires, a monitor compares each presented response.
module tb_banked_mem_ctrl;

  localparam int DW = 32;
  localparam int AW = 14;
  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req_valid, i_req_ready;
  logic [AW-1:0] i_req_addr;
  logic          i_rsp_valid;
  logic [DW-1:0] i_rsp_data;
  logic          d_req_valid, d_req_ready, d_req_we;
  logic [AW-1:0] d_req_addr;
  logic [3:0]    d_req_be;
  logic [DW-1:0] d_req_wdata;
  logic          d_rsp_valid;
  logic [DW-1:0] d_rsp_data;

  always #5 clk = ~clk;

  banked_mem_ctrl #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .NUM_BANKS (NB),
    .INIT_PRIO (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req_valid (i_req_valid),
    .i_req_ready (i_req_ready),
    .i_req_addr  (i_req_addr),
    .i_rsp_valid (i_rsp_valid),
    .i_rsp_data  (i_rsp_data),
    .d_req_valid (d_req_valid),
    .d_req_ready (d_req_ready),
    .d_req_we    (d_req_we),
    .d_req_addr  (d_req_addr),
    .d_req_be    (d_req_be),
    .d_req_wdata (d_req_wdata),
    .d_rsp_valid (d_rsp_valid),
    .d_rsp_data  (d_rsp_data)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] i_exp_q[$];
  logic [DW-1:0] d_exp_q[$];

  // Preload pattern: distinct per address, hand-checkable
  function automatic logic [31:0] pat(input logic [13:0] a);
    return 32'h5A00_0000 ^ {2'b00, a, 2'b00, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Monitor: every presented response must match the oldest expectation
  initial begin
    forever begin
      @(negedge clk);
      if (i_rsp_valid) begin
        if (i_exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL i_rsp_unexpected: got 0x%08h, expected no response", i_rsp_data);
        end else begin
          chk("i_rsp_data", i_rsp_data, i_exp_q.pop_front());
        end
      end
      if (d_rsp_valid) begin
        if (d_exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL d_rsp_unexpected: got 0x%08h, expected no response", d_rsp_data);
        end else begin
          chk("d_rsp_data", d_rsp_data, d_exp_q.pop_front());
        end
      end
    end
  end

  // One clock of stimulus; returns readies and i_rsp_valid seen mid-cycle
  task automatic cycle(input logic iv, input logic [13:0] ia, input logic [31:0] iexp,
                       input logic dv, input logic dwe, input logic [13:0] da,
                       input logic [3:0] dbe, input logic [31:0] dwd, input logic [31:0] dexp,
                       output logic igr, output logic dgr, output logic irv);
    i_req_valid = iv;  i_req_addr = ia;
    d_req_valid = dv;  d_req_we = dwe; d_req_addr = da;
    d_req_be    = dbe; d_req_wdata = dwd;
    @(negedge clk);
    igr = i_req_ready;
    dgr = d_req_ready;
    irv = i_rsp_valid;
    if (iv && i_req_ready) i_exp_q.push_back(iexp);
    if (dv && d_req_ready && !dwe) d_exp_q.push_back(dexp);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    logic a, b, c;
    cycle(0, '0, '0, 0, 0, '0, '0, '0, '0, a, b, c);
  endtask

  task automatic wr(input logic [13:0] a, input logic [3:0] be, input logic [31:0] wd);
    logic ig, dg, irv;
    cycle(0, '0, '0, 1, 1, a, be, wd, '0, ig, dg, irv);
    chk("wr_d_ready", dg, 1'b1);
  endtask

  task automatic d_rd(input logic [13:0] a, input logic [31:0] exp);
    logic ig, dg, irv;
    cycle(0, '0, '0, 1, 0, a, '0, '0, exp, ig, dg, irv);
    chk("rd_d_ready", dg, 1'b1);
  endtask

  initial begin
    logic ig, dg, irv;
    logic [13:0] preload [20];

    i_req_valid = 0; i_req_addr = '0;
    d_req_valid = 0; d_req_we = 0; d_req_addr = '0; d_req_be = '0; d_req_wdata = '0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_i_rsp_valid", i_rsp_valid, 1'b0);
    chk("reset_d_rsp_valid", d_rsp_valid, 1'b0);
    chk("reset_i_rsp_data",  i_rsp_data,  32'h0);
    chk("reset_d_rsp_data",  d_rsp_data,  32'h0);
    rst = 1'b1;
    idle();

    // Preload through the data port
    preload[0] = 14'h000; preload[1] = 14'h001; preload[2] = 14'h002; preload[3] = 14'h004;
    for (int k = 0; k < 16; k++) preload[4 + k] = 14'h020 + 14'(k);
    for (int k = 0; k < 20; k++) wr(preload[k], 4'hF, pat(preload[k]));

    // No conflict: different banks serviced together
    cycle(1, 14'h001, pat(14'h001), 1, 0, 14'h002, '0, '0, pat(14'h002), ig, dg, irv);
    chk("t2_i_ready", ig, 1'b1);
    chk("t2_d_ready", dg, 1'b1);
    idle();

    // Byte-masked write merge, then an all-zero mask is a no-op
    wr(14'h010, 4'hF, 32'h1122_3344);
    wr(14'h010, 4'b0101, 32'hAABB_CCDD);
    d_rd(14'h010, 32'h11BB_33DD);
    wr(14'h010, 4'b0000, 32'hFFFF_FFFF);
    d_rd(14'h010, 32'h11BB_33DD);

    // Highest address: last row of the last bank
    wr(14'h3FFF, 4'hF, 32'h0BAD_F00D);
    d_rd(14'h3FFF, 32'h0BAD_F00D);

    // Write then next-cycle instruction read of the same word
    wr(14'h0FF, 4'hF, 32'hDEAD_BEEF);
    cycle(1, 14'h0FF, 32'hDEAD_BEEF, 0, 0, '0, '0, '0, '0, ig, dg, irv);
    chk("t5_i_ready", ig, 1'b1);
    idle();

    // Streaming: 16 consecutive instruction reads, no bubbles
    for (int k = 0; k < 16; k++) begin
      cycle(1, 14'h020 + 14'(k), pat(14'h020 + 14'(k)), 0, 0, '0, '0, '0, '0, ig, dg, irv);
      chk("t6_i_ready", ig, 1'b1);
      if (k > 0) chk("t6_stream_valid", irv, 1'b1);
    end
    cycle(0, '0, '0, 0, 0, '0, '0, '0, '0, ig, dg, irv);
    chk("t6_stream_last_valid", irv, 1'b1);
    idle();

    // Conflict fairness on bank 0: D, I, D, I
    for (int c = 0; c < 4; c++) begin
      cycle(1, 14'h000, pat(14'h000), 1, 0, 14'h004, '0, '0, pat(14'h004), ig, dg, irv);
      chk("t4_d_ready", dg, (c % 2 == 0) ? 1'b1 : 1'b0);
      chk("t4_i_ready", ig, (c % 2 == 0) ? 1'b0 : 1'b1);
    end
    idle();
    idle();

    // Reset with responses in flight; pointer returns to D
    cycle(1, 14'h001, pat(14'h001), 1, 0, 14'h002, '0, '0, pat(14'h002), ig, dg, irv);
    i_req_valid = 0; d_req_valid = 0;
    rst = 1'b0;
    #1;
    chk("t1_i_rsp_valid", i_rsp_valid, 1'b0);
    chk("t1_d_rsp_valid", d_rsp_valid, 1'b0);
    chk("t1_i_rsp_data",  i_rsp_data,  32'h0);
    chk("t1_d_rsp_data",  d_rsp_data,  32'h0);
    i_exp_q.delete();
    d_exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cycle(1, 14'h000, pat(14'h000), 1, 0, 14'h004, '0, '0, pat(14'h004), ig, dg, irv);
    chk("t1_conflict_d_ready", dg, 1'b1);
    chk("t1_conflict_i_ready", ig, 1'b0);
    cycle(1, 14'h000, pat(14'h000), 0, 0, '0, '0, '0, '0, ig, dg, irv);
    chk("t1_retry_i_ready", ig, 1'b1);

    repeat (4) idle();
    chk("queues_drained", 32'(i_exp_q.size() + d_exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
